// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes a subset of RV32 ALU instructions, resolves
// operand forwarding at capture time, and holds one entry under valid/ready flow control.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            fwd_mem_en,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_en,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [2:0]      alu_control,
    output logic [4:0]      rd_out,
    output logic            illegal,
    output logic [15:0]     issued
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SRA = 3'b010,
        ALU_SRL = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110
    } alu_op_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic            capture;
    logic            drain;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [4:0]      dec_rd;
    alu_op_t         dec_op;
    logic            dec_illegal;
    logic            is_r;
    logic            is_i;

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign capture  = in_valid && in_ready;
    assign drain    = out_valid && out_ready && !flush;

    // Register x0 reads as zero, so an addr match against rd==0 never forwards.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        rs1_val = rs1_data;
        if (rs1_addr == 5'd0)
            rs1_val = '0;
        else if (fwd_mem_en && fwd_mem_rd == rs1_addr)
            rs1_val = fwd_mem_data;
        else if (fwd_wb_en && fwd_wb_rd == rs1_addr)
            rs1_val = fwd_wb_data;

        rs2_val = rs2_data;
        if (rs2_addr == 5'd0)
            rs2_val = '0;
        else if (fwd_mem_en && fwd_mem_rd == rs2_addr)
            rs2_val = fwd_mem_data;
        else if (fwd_wb_en && fwd_wb_rd == rs2_addr)
            rs2_val = fwd_wb_data;
    end

    always_comb begin
        is_r        = (opcode == OP_R);
        is_i        = (opcode == OP_I);
        dec_op      = ALU_ADD;
        dec_illegal = 1'b1;
        dec_a       = '0;
        dec_b       = '0;
        dec_rd      = '0;

        if (is_r || is_i) begin
            dec_illegal = 1'b0;
            case (funct3)
                3'b000:  dec_op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b101:  dec_op = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  dec_op = ALU_OR;
                3'b111:  dec_op = ALU_AND;
                default: dec_illegal = 1'b1;
            endcase
        end

        if (!dec_illegal) begin
            dec_a  = rs1_val;
            dec_rd = rd_addr;
            if (is_r)
                dec_b = rs2_val;
            else if (funct3 == 3'b101)
                dec_b = XLEN'(imm[4:0]);
            else
                dec_b = imm;
        end
    end

    // Flush outranks capture; a drain with no capture empties the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            out_valid   <= 1'b0;
            a           <= '0;
            b           <= '0;
            alu_control <= 3'b000;
            rd_out      <= 5'd0;
            illegal     <= 1'b0;
            issued      <= 16'd0;
        end else begin
            if (drain)
                issued <= issued + 16'd1;

            if (flush)
                out_valid <= 1'b0;
            else if (capture)
                out_valid <= 1'b1;
            else if (out_valid && out_ready)
                out_valid <= 1'b0;

            if (capture) begin
                a           <= dec_a;
                b           <= dec_b;
                alu_control <= dec_op;
                rd_out      <= dec_rd;
                illegal     <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic compared against
// a behavioural model of the stage's transfer and decode rules.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            fwd_mem_en, fwd_wb_en;
    logic [4:0]      fwd_mem_rd, fwd_wb_rd;
    logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
    logic            flush, out_ready;
    logic            out_valid;
    logic [XLEN-1:0] a, b;
    logic [2:0]      alu_control;
    logic [4:0]      rd_out;
    logic            illegal;
    logic [15:0]     issued;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .a(a), .b(b), .alu_control(alu_control), .rd_out(rd_out),
        .illegal(illegal), .issued(issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      ctl;
        logic [4:0]      rd;
        logic            ill;
    } entry_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic        m_valid;
    entry_t      m_entry;
    logic [15:0] m_issued;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] operand(input logic [4:0] addr, input logic [XLEN-1:0] rf);
        if (addr == 0) return '0;
        if (fwd_mem_en && fwd_mem_rd == addr) return fwd_mem_data;
        if (fwd_wb_en && fwd_wb_rd == addr) return fwd_wb_data;
        return rf;
    endfunction

    function automatic entry_t ref_decode();
        entry_t e;
        bit     r_type = (opcode == 7'h33);
        e = '{a: '0, b: '0, ctl: 3'd0, rd: 5'd0, ill: 1'b1};
        if ((opcode == 7'h33 || opcode == 7'h13) && funct3 inside {3'd0, 3'd5, 3'd6, 3'd7}) begin
            e.ill = 1'b0;
            e.rd  = rd_addr;
            e.a   = operand(rs1_addr, rs1_data);
            case (funct3)
                3'd0:    e.ctl = (r_type && funct7_5) ? 3'd1 : 3'd0;
                3'd5:    e.ctl = funct7_5 ? 3'd2 : 3'd4;
                3'd6:    e.ctl = 3'd6;
                default: e.ctl = 3'd5;
            endcase
            if (r_type)          e.b = operand(rs2_addr, rs2_data);
            else if (funct3 == 5) e.b = imm % 32;
            else                 e.b = imm;
        end
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".issued"}, 32'(issued), 32'(m_issued));
        if (m_valid) begin
            check({tag, ".a"}, a, m_entry.a);
            check({tag, ".b"}, b, m_entry.b);
            check({tag, ".alu_control"}, 32'(alu_control), 32'(m_entry.ctl));
            check({tag, ".rd_out"}, 32'(rd_out), 32'(m_entry.rd));
            check({tag, ".illegal"}, 32'(illegal), 32'(m_entry.ill));
        end
    endtask

    // Inputs are set just after a posedge; this evaluates one clock edge.
    task automatic step(input string tag, input bit do_check);
        bit exp_ready, take, drain;
        #1;
        exp_ready = (!m_valid || out_ready) && !flush;
        if (do_check) check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        take  = in_valid && exp_ready;
        drain = m_valid && out_ready && !flush;
        if (drain) m_issued = m_issued + 1;
        if (flush) m_valid = 1'b0;
        else if (take) begin
            m_valid = 1'b1;
            m_entry = ref_decode();
        end else if (drain) m_valid = 1'b0;
        @(posedge clk);
        #1;
        if (do_check) check_outputs(tag);
    endtask

    task automatic set_idle();
        in_valid = 0; opcode = 0; funct3 = 0; funct7_5 = 0; imm = 0;
        rs1_addr = 0; rs2_addr = 0; rd_addr = 0; rs1_data = 0; rs2_data = 0;
        fwd_mem_en = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
        fwd_wb_en = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
        in_valid = 1; opcode = op; funct3 = f3; funct7_5 = f7;
        rs1_addr = r1; rs2_addr = r2; rd_addr = rd; rs1_data = d1; rs2_data = d2;
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_issued = 16'd0;
        m_entry  = '{a: '0, b: '0, ctl: 3'd0, rd: 5'd0, ill: 1'b0};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".a"}, a, 32'd0);
        check({tag, ".b"}, b, 32'd0);
        check({tag, ".alu_control"}, 32'(alu_control), 32'd0);
        check({tag, ".rd_out"}, 32'(rd_out), 32'd0);
        check({tag, ".illegal"}, 32'(illegal), 32'd0);
        check({tag, ".issued"}, 32'(issued), 32'd0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic randomize_inputs();
        case ($urandom_range(0, 3))
            0: opcode = 7'h33;
            1: opcode = 7'h13;
            2: opcode = 7'h03;
            default: opcode = 7'($urandom);
        endcase
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 15) == 0);
        funct3 = 3'($urandom); funct7_5 = 1'($urandom); imm = $urandom;
        rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
        rd_addr = 5'($urandom);
        rs1_data = $urandom; rs2_data = $urandom;
        fwd_mem_en = 1'($urandom); fwd_mem_rd = 5'($urandom_range(0, 7)); fwd_mem_data = $urandom;
        fwd_wb_en = 1'($urandom); fwd_wb_rd = 5'($urandom_range(0, 7)); fwd_wb_data = $urandom;
    endtask

    initial begin
        set_idle();
        model_reset();
        rst_n = 0;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1;

        // R-type add with plain register-file operands.
        set_instr(7'h33, 3'd0, 1'b0, 5'd5, 5'd6, 5'd9, 32'd2, 32'd3);
        step("add", 1);
        check("add.a_const", a, 32'd2);
        check("add.ctl_const", 32'(alu_control), 32'd0);

        set_instr(7'h33, 3'd5, 1'b1, 5'd5, 5'd6, 5'd10, 32'hFFFF_F000, 32'd4);
        step("sra", 1);
        check("sra.ctl_const", 32'(alu_control), 32'd2);
        set_instr(7'h33, 3'd5, 1'b0, 5'd5, 5'd6, 5'd10, 32'hFFFF_F000, 32'd4);
        step("srl", 1);
        set_instr(7'h33, 3'd0, 1'b1, 5'd3, 5'd4, 5'd1, 32'd50, 32'd8);
        step("sub", 1);

        // I-type shift takes only imm[4:0] zero-extended.
        set_instr(7'h13, 3'd5, 1'b1, 5'd3, 5'd0, 5'd2, 32'h8000_0000, 32'd0);
        imm = 32'hFFFF_FFE7;
        step("srai", 1);
        set_instr(7'h13, 3'd6, 1'b0, 5'd3, 5'd0, 5'd2, 32'h0F0F, 32'd0);
        step("ori", 1);

        // MEM forward wins over WB; x0 never forwards.
        set_instr(7'h33, 3'd7, 1'b0, 5'd7, 5'd0, 5'd3, 32'h1111, 32'd0);
        fwd_mem_en = 1; fwd_mem_rd = 5'd7; fwd_mem_data = 32'hAAAA;
        fwd_wb_en = 1; fwd_wb_rd = 5'd7; fwd_wb_data = 32'hBBBB;
        step("fwd_mem", 1);
        check("fwd_mem.a_const", a, 32'hAAAA);
        rs1_addr = 5'd0; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
        step("fwd_x0", 1);
        check("fwd_x0.a_const", a, 32'd0);
        set_idle();

        // Stall for 3 cycles, then release: drain and reload on the same edge.
        set_instr(7'h33, 3'd6, 1'b0, 5'd1, 5'd2, 5'd4, 32'h10, 32'h20);
        step("stall_load", 1);
        out_ready = 0;
        rs1_data = 32'h99;
        for (int i = 0; i < 3; i++) step("stall_hold", 1);
        out_ready = 1;
        step("stall_release", 1);

        set_instr(7'h03, 3'd0, 1'b0, 5'd1, 5'd2, 5'd4, 32'h10, 32'h20);
        step("illegal_op", 1);
        set_instr(7'h33, 3'd1, 1'b0, 5'd1, 5'd2, 5'd4, 32'h10, 32'h20);
        step("illegal_f3", 1);
        flush = 1;
        step("flush", 1);
        flush = 0;
        in_valid = 0;
        step("after_flush", 1);

        // Reset mid-stall discards the held entry; asynchronous clear.
        set_instr(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd4, 32'h5, 32'h6);
        step("pre_rst_load", 1);
        out_ready = 0;
        step("pre_rst_stall", 1);
        #3;
        rst_n = 0;
        #1;
        model_reset();
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1;
        step("post_rst", 1);

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step("random", 1);
        end

        // Wrap of the transfer counter.
        set_idle();
        rst_n = 0;
        #1;
        model_reset();
        rst_n = 1;
        @(posedge clk);
        #1;
        set_instr(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd1, 32'd1, 32'd0);
        for (int i = 0; i < 70000 && m_issued != 16'hFFFF; i++) step("bulk", 0);
        check("wrap.preload", 32'(issued), 32'h0000_FFFF);
        step("wrap", 1);
        check("wrap.zero", 32'(issued), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
